issue_dual_sb: RTL and testbench

- Parametrised dual-issue launch stage sitting between decode and the two execution units.
- Buffers a decoded instruction pair and routes each instruction to a capable execution unit (EU).
- Stalls on register hazards via a per-register scoreboard and in-order pairing rules.
- Reads the register file and presents registered operands with a valid/ready handshake per EU.

---
 rtl/issue_dual_sb.sv | 273 +++++++++++++++++++++++++++
 tb/tb_issue_dual_sb.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_dual_sb.sv
`default_nettype none
// ============================================================================
// Module   : issue_dual_sb
// Purpose  : Dual-issue launch stage placed between decode and two execution
//            units. It buffers a decoded instruction pair, blocks issue on
//            register hazards using a per-register scoreboard and in-order
//            pairing rules, reads the register file, and presents registered
//            operands to each EU through a valid/ready handshake.
// Ports    : clk, rst (sync, active high), flush
//            in_*    : decoded pair from decode (in_valid/in_ready handshake)
//            rf_*    : 4 combinational register-file read ports
//            wb_*    : 2 writeback ports that clear scoreboard entries
//            eu_*    : EU0 (ALU/BRU) and EU1 (ALU/LSU) output registers
//            l_flag  : one-cycle pulse showing which slot went to which EU
// Option   : ISSUE_WB_BYPASS_EN - a source that matches a same-cycle
//            writeback is not held back by the scoreboard and takes wb_data.
// Revision : 1.0 - initial release
// ============================================================================
module issue_dual_sb #(
  parameter int PC_W  = 32,
  parameter int DEC_W = 72,
  parameter int XLEN  = 32,
  parameter int RA_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [1:0]          in_valid,
  output logic                in_ready,
  input  logic [2*PC_W-1:0]   in_pc,
  input  logic [2*PC_W-1:0]   in_npc,
  input  logic [2*DEC_W-1:0]  in_dec,
  input  logic [2*RA_W-1:0]   in_rs1,
  input  logic [2*RA_W-1:0]   in_rs2,
  input  logic [2*RA_W-1:0]   in_rd,
  input  logic [1:0]          in_we,
  input  logic [3:0]          in_cls,
  output logic [4*RA_W-1:0]   rf_raddr,
  input  logic [4*XLEN-1:0]   rf_rdata,
  input  logic [1:0]          wb_valid,
  input  logic [2*RA_W-1:0]   wb_rd,
  input  logic [2*XLEN-1:0]   wb_data,
  output logic [1:0]          eu_valid,
  input  logic [1:0]          eu_ready,
  output logic [2*PC_W-1:0]   eu_pc,
  output logic [2*PC_W-1:0]   eu_npc,
  output logic [2*DEC_W-1:0]  eu_dec,
  output logic [2*XLEN-1:0]   eu_rdata1,
  output logic [2*XLEN-1:0]   eu_rdata2,
  output logic [2*RA_W-1:0]   eu_rd,
  output logic [1:0]          eu_we,
  output logic [3:0]          l_flag
);

  localparam int         NREG    = 1 << RA_W;
  localparam logic [1:0] CLS_BRU = 2'd1;
  localparam logic [1:0] CLS_LSU = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  npc;
    logic [DEC_W-1:0] dec;
    logic [RA_W-1:0]  rs1;
    logic [RA_W-1:0]  rs2;
    logic [RA_W-1:0]  rd;
    logic             we;
    logic [1:0]       cls;
  } hold_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  npc;
    logic [DEC_W-1:0] dec;
    logic [RA_W-1:0]  rd;
    logic             we;
    logic [XLEN-1:0]  d1;
    logic [XLEN-1:0]  d2;
  } eu_t;

  hold_t           w_in [2];
  hold_t           r_h  [2];
  logic [1:0]      r_hcnt;
  logic [1:0]      w_hcnt_nxt;
  logic            r_in_ready;
  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_pend_nxt;
  eu_t             r_eu [2];
  eu_t             w_new [2];
  logic [1:0]      r_eu_valid;
  logic [3:0]      r_l_flag;

  logic [RA_W-1:0] w_src [4];
  logic [3:0]      w_haz;
  logic [XLEN-1:0] w_opnd [4];
  logic            w_accept;
  logic [1:0]      w_free, w_sel0, w_sel1;
  logic            w_iss0, w_iss1, w_intra;

  // EU choice by class: BRU only on EU0, LSU only on EU1, ALU prefers EU0.
  function automatic logic [1:0] pick_eu(input logic [1:0] cls, input logic [1:0] free);
    logic [1:0] sel;
    sel = 2'b00;
    case (cls)
      CLS_BRU: sel = {1'b0, free[0]};
      CLS_LSU: sel = {free[1], 1'b0};
      default: sel = free[0] ? 2'b01 : {free[1], 1'b0};
    endcase
    return sel;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_in
      assign w_in[gi].pc  = in_pc[gi*PC_W +: PC_W];
      assign w_in[gi].npc = in_npc[gi*PC_W +: PC_W];
      assign w_in[gi].dec = in_dec[gi*DEC_W +: DEC_W];
      assign w_in[gi].rs1 = in_rs1[gi*RA_W +: RA_W];
      assign w_in[gi].rs2 = in_rs2[gi*RA_W +: RA_W];
      assign w_in[gi].rd  = in_rd[gi*RA_W +: RA_W];
      assign w_in[gi].we  = in_we[gi];
      assign w_in[gi].cls = in_cls[gi*2 +: 2];
    end
  endgenerate

  // Source order matches the register-file port order {s1rs2,s1rs1,s0rs2,s0rs1}.
  assign w_src[0] = r_h[0].rs1;
  assign w_src[1] = r_h[0].rs2;
  assign w_src[2] = r_h[1].rs1;
  assign w_src[3] = r_h[1].rs2;
  assign rf_raddr = {w_src[3], w_src[2], w_src[1], w_src[0]};

  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
      logic w_pend;
      logic w_out_match;
      // An instruction still sitting in an EU register has not set its
      // pending bit yet, so it must be checked directly.
      assign w_out_match = (r_eu_valid[0] && r_eu[0].we && (r_eu[0].rd == w_src[gi])) ||
                           (r_eu_valid[1] && r_eu[1].we && (r_eu[1].rd == w_src[gi]));
`ifdef ISSUE_WB_BYPASS_EN
      logic w_wb0, w_wb1;
      assign w_wb0 = wb_valid[0] && (wb_rd[RA_W-1:0] == w_src[gi]);
      assign w_wb1 = wb_valid[1] && (wb_rd[2*RA_W-1:RA_W] == w_src[gi]);
      assign w_pend = r_pending[w_src[gi]] && !(w_wb0 || w_wb1);
      assign w_opnd[gi] = (w_src[gi] == '0) ? '0 :
                          w_wb1 ? wb_data[2*XLEN-1:XLEN] :
                          w_wb0 ? wb_data[XLEN-1:0] :
                          rf_rdata[gi*XLEN +: XLEN];
`else
      assign w_pend = r_pending[w_src[gi]];
      assign w_opnd[gi] = (w_src[gi] == '0) ? '0 : rf_rdata[gi*XLEN +: XLEN];
`endif
      assign w_haz[gi] = (w_src[gi] != '0) && (w_pend || w_out_match);
    end
  endgenerate

`ifdef ISSUE_WB_BYPASS_EN
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  assign w_accept = r_in_ready && (in_valid != 2'b00) && !flush;

  always_comb begin
    w_free  = ~r_eu_valid | eu_ready;
    w_sel0  = pick_eu(r_h[0].cls, w_free);
    w_iss0  = !flush && (r_hcnt != 2'd0) && !w_haz[0] && !w_haz[1] &&
              !r_pending[r_h[0].rd] && (w_sel0 != 2'b00);
    // h1 may only use the EU left over after h0's pick.
    w_sel1  = pick_eu(r_h[1].cls, w_free & ~w_sel0);
    w_intra = r_h[0].we && (r_h[0].rd != '0) &&
              ((r_h[0].rd == r_h[1].rs1) || (r_h[0].rd == r_h[1].rs2) ||
               (r_h[0].rd == r_h[1].rd));
    w_iss1  = w_iss0 && (r_hcnt == 2'd2) && !w_haz[2] && !w_haz[3] &&
              !r_pending[r_h[1].rd] && !w_intra && (w_sel1 != 2'b00);
  end

  always_comb begin
    w_hcnt_nxt = r_hcnt;
    if (flush)         w_hcnt_nxt = 2'd0;
    else if (w_accept) w_hcnt_nxt = (in_valid == 2'b11) ? 2'd2 : 2'd1;
    else if (w_iss1)   w_hcnt_nxt = 2'd0;
    else if (w_iss0)   w_hcnt_nxt = r_hcnt - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt     <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      r_hcnt     <= w_hcnt_nxt;
      r_in_ready <= (w_hcnt_nxt == 2'd0);
    end
  end

  // Entry payload is qualified by r_hcnt, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!flush && w_accept) begin
      r_h[0] <= in_valid[0] ? w_in[0] : w_in[1];
      r_h[1] <= w_in[1];
    end else if (!flush && w_iss0 && !w_iss1) begin
      r_h[0] <= r_h[1];
    end
  end

  always_comb begin
    w_new[0].pc  = r_h[0].pc;
    w_new[0].npc = r_h[0].npc;
    w_new[0].dec = r_h[0].dec;
    w_new[0].rd  = r_h[0].rd;
    w_new[0].we  = r_h[0].we;
    w_new[0].d1  = w_opnd[0];
    w_new[0].d2  = w_opnd[1];
    w_new[1].pc  = r_h[1].pc;
    w_new[1].npc = r_h[1].npc;
    w_new[1].dec = r_h[1].dec;
    w_new[1].rd  = r_h[1].rd;
    w_new[1].we  = r_h[1].we;
    w_new[1].d1  = w_opnd[2];
    w_new[1].d2  = w_opnd[3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_eu_valid <= 2'b00;
      r_l_flag   <= 4'b0000;
      r_eu[0]    <= '0;
      r_eu[1]    <= '0;
    end else begin
      r_l_flag <= {(w_iss1 ? w_sel1 : 2'b00), (w_iss0 ? w_sel0 : 2'b00)};
      for (int k = 0; k < 2; k++) begin
        if (flush)                        r_eu_valid[k] <= 1'b0;
        else if (w_iss0 && w_sel0[k])     r_eu_valid[k] <= 1'b1;
        else if (w_iss1 && w_sel1[k])     r_eu_valid[k] <= 1'b1;
        else if (eu_ready[k])             r_eu_valid[k] <= 1'b0;
        if (w_iss0 && w_sel0[k])          r_eu[k] <= w_new[0];
        else if (w_iss1 && w_sel1[k])     r_eu[k] <= w_new[1];
      end
    end
  end

  // Clear beats set; register 0 is never tracked.
  always_comb begin
    w_pend_nxt = r_pending;
    for (int k = 0; k < 2; k++) begin
      if (r_eu_valid[k] && eu_ready[k] && r_eu[k].we && (r_eu[k].rd != '0))
        w_pend_nxt[r_eu[k].rd] = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      if (wb_valid[i]) w_pend_nxt[wb_rd[i*RA_W +: RA_W]] = 1'b0;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= w_pend_nxt;
  end

  assign in_ready  = r_in_ready;
  assign eu_valid  = r_eu_valid;
  assign l_flag    = r_l_flag;
  assign eu_pc     = {r_eu[1].pc,  r_eu[0].pc};
  assign eu_npc    = {r_eu[1].npc, r_eu[0].npc};
  assign eu_dec    = {r_eu[1].dec, r_eu[0].dec};
  assign eu_rdata1 = {r_eu[1].d1,  r_eu[0].d1};
  assign eu_rdata2 = {r_eu[1].d2,  r_eu[0].d2};
  assign eu_rd     = {r_eu[1].rd,  r_eu[0].rd};
  assign eu_we     = {r_eu[1].we,  r_eu[0].we};

endmodule
`default_nettype wire

// File: tb/tb_issue_dual_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_dual_sb
// Purpose  : Directed self-checking bench for issue_dual_sb. The register
//            file is modelled as register a reading 0x100 + a.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_dual_sb;
  localparam int PC_W  = 32;
  localparam int DEC_W = 72;
  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam logic [1:0] ALU = 2'd0;
  localparam logic [1:0] BRU = 2'd1;
  localparam logic [1:0] LSU = 2'd2;

  logic               clk = 1'b0;
  logic               rst, flush;
  logic [1:0]         in_valid;
  logic               in_ready;
  logic [2*PC_W-1:0]  in_pc, in_npc;
  logic [2*DEC_W-1:0] in_dec;
  logic [2*RA_W-1:0]  in_rs1, in_rs2, in_rd;
  logic [1:0]         in_we;
  logic [3:0]         in_cls;
  logic [4*RA_W-1:0]  rf_raddr;
  logic [4*XLEN-1:0]  rf_rdata;
  logic [1:0]         wb_valid;
  logic [2*RA_W-1:0]  wb_rd;
  logic [2*XLEN-1:0]  wb_data;
  logic [1:0]         eu_valid, eu_ready;
  logic [2*PC_W-1:0]  eu_pc, eu_npc;
  logic [2*DEC_W-1:0] eu_dec;
  logic [2*XLEN-1:0]  eu_rdata1, eu_rdata2;
  logic [2*RA_W-1:0]  eu_rd;
  logic [1:0]         eu_we;
  logic [3:0]         l_flag;

  int checks = 0;
  int errors = 0;

  issue_dual_sb #(.PC_W(PC_W), .DEC_W(DEC_W), .XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_npc(in_npc),
    .in_dec(in_dec), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_we(in_we), .in_cls(in_cls), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .eu_valid(eu_valid), .eu_ready(eu_ready), .eu_pc(eu_pc), .eu_npc(eu_npc),
    .eu_dec(eu_dec), .eu_rdata1(eu_rdata1), .eu_rdata2(eu_rdata2),
    .eu_rd(eu_rd), .eu_we(eu_we), .l_flag(l_flag)
  );

  always #5 clk = ~clk;

  always_comb begin
    rf_rdata = '0;
    for (int j = 0; j < 4; j++)
      rf_rdata[j*XLEN +: XLEN] = 32'h100 + 32'(rf_raddr[j*RA_W +: RA_W]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic [31:0] pc, input logic [1:0] cls,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we);
    in_pc[s*PC_W +: PC_W]    = pc;
    in_npc[s*PC_W +: PC_W]   = pc + 32'd4;
    in_dec[s*DEC_W +: DEC_W] = {40'h0, pc};
    in_rs1[s*RA_W +: RA_W]   = rs1;
    in_rs2[s*RA_W +: RA_W]   = rs2;
    in_rd[s*RA_W +: RA_W]    = rd;
    in_we[s]                 = we;
    in_cls[s*2 +: 2]         = cls;
  endtask

  task automatic accept(input logic [1:0] v);
    in_valid = v;
    step();
    in_valid = 2'b00;
  endtask

  task automatic wb_one(input logic [4:0] rd);
    wb_valid = 2'b01;
    wb_rd[4:0] = rd;
    step();
    wb_valid = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1;
    in_valid = 2'b00; in_pc = '0; in_npc = '0; in_dec = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_we = '0; in_cls = '0;
    wb_valid = '0; wb_rd = '0; wb_data = '0; eu_ready = 2'b00;
    repeat (3) step();
    rst = 1'b0; flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (eu_valid !== 2'b00) begin errors++; $display("FAIL reset_eu_valid got %b want 00", eu_valid); end
    checks++; if (l_flag !== 4'b0000) begin errors++; $display("FAIL reset_l_flag got %b want 0000", l_flag); end
    checks++; if (eu_pc !== '0 || eu_rdata1 !== '0 || eu_we !== 2'b00)
      begin errors++; $display("FAIL reset_eu_data got pc=%h d1=%h we=%b want 0", eu_pc, eu_rdata1, eu_we); end
  endtask

  task automatic test_pair();
    eu_ready = 2'b11;
    set_slot(0, 32'h100, ALU, 5'd1, 5'd2, 5'd1, 1'b1);
    set_slot(1, 32'h104, LSU, 5'd3, 5'd0, 5'd2, 1'b1);
    accept(2'b11);
    checks++; if (in_ready !== 1'b0 || eu_valid !== 2'b00)
      begin errors++; $display("FAIL pair_accept got rdy=%b v=%b want 0/00", in_ready, eu_valid); end
    step();
    checks++; if (eu_valid !== 2'b11) begin errors++; $display("FAIL pair_eu_valid got %b want 11", eu_valid); end
    checks++; if (l_flag !== 4'b1001) begin errors++; $display("FAIL pair_l_flag got %b want 1001", l_flag); end
    checks++; if (eu_pc !== {32'h104, 32'h100} || eu_npc[63:32] !== 32'h108)
      begin errors++; $display("FAIL pair_pc got %h/%h want 104_100/108", eu_pc, eu_npc); end
    checks++; if (eu_dec[DEC_W-1:0] !== {40'h0, 32'h100})
      begin errors++; $display("FAIL pair_dec got %h want 100", eu_dec[DEC_W-1:0]); end
    checks++; if (eu_rdata1 !== {32'h103, 32'h101} || eu_rdata2 !== {32'h0, 32'h102})
      begin errors++; $display("FAIL pair_data got %h %h want 103_101 0_102", eu_rdata1, eu_rdata2); end
    checks++; if (eu_rd !== {5'd2, 5'd1} || eu_we !== 2'b11)
      begin errors++; $display("FAIL pair_rd got %h we=%b want 2/1 11", eu_rd, eu_we); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pair_in_ready got %b want 1", in_ready); end
    step();
    checks++; if (eu_valid !== 2'b00 || l_flag !== 4'b0000)
      begin errors++; $display("FAIL pair_drain got v=%b f=%b want 00/0000", eu_valid, l_flag); end
    wb_valid = 2'b11; wb_rd = {5'd2, 5'd1};
    step();
    wb_valid = 2'b00;
  endtask

  task automatic test_intra_raw();
    eu_ready = 2'b11;
    set_slot(0, 32'h200, ALU, 5'd1, 5'd2, 5'd5, 1'b1);
    set_slot(1, 32'h204, ALU, 5'd5, 5'd1, 5'd6, 1'b1);
    accept(2'b11);
    step();
    checks++; if (l_flag !== 4'b0001 || eu_valid !== 2'b01)
      begin errors++; $display("FAIL raw_first got f=%b v=%b want 0001/01", l_flag, eu_valid); end
    checks++; if (eu_pc[31:0] !== 32'h200 || in_ready !== 1'b0)
      begin errors++; $display("FAIL raw_first_pc got %h rdy=%b want 200/0", eu_pc[31:0], in_ready); end
    step();
    checks++; if (eu_valid !== 2'b00 || l_flag !== 4'b0000)
      begin errors++; $display("FAIL raw_outreg_stall got v=%b f=%b want 00/0000", eu_valid, l_flag); end
    step();
    checks++; if (eu_valid !== 2'b00) begin errors++; $display("FAIL raw_pending_stall got %b want 00", eu_valid); end
    wb_valid = 2'b01; wb_rd[4:0] = 5'd5; wb_data[31:0] = 32'hCAFE_0005;
    step();
    wb_valid = 2'b00;
`ifdef ISSUE_WB_BYPASS_EN
    checks++; if (eu_valid !== 2'b01 || eu_rdata1[31:0] !== 32'hCAFE_0005)
      begin errors++; $display("FAIL raw_bypass got v=%b d1=%h want 01/cafe0005", eu_valid, eu_rdata1[31:0]); end
`else
    checks++; if (eu_valid !== 2'b00) begin errors++; $display("FAIL raw_wb_cycle got %b want 00", eu_valid); end
    step();
    checks++; if (eu_valid !== 2'b01 || l_flag !== 4'b0001)
      begin errors++; $display("FAIL raw_second got v=%b f=%b want 01/0001", eu_valid, l_flag); end
    checks++; if (eu_pc[31:0] !== 32'h204 || eu_rdata1[31:0] !== 32'h105 || eu_rdata2[31:0] !== 32'h101)
      begin errors++; $display("FAIL raw_second_data got %h %h %h want 204 105 101", eu_pc[31:0], eu_rdata1[31:0], eu_rdata2[31:0]); end
`endif
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_in_ready got %b want 1", in_ready); end
    step();
    wb_one(5'd6);
  endtask

  task automatic test_scoreboard();
    eu_ready = 2'b11;
    set_slot(0, 32'h5F0, BRU, 5'd9, 5'd9, 5'd9, 1'b1);
    set_slot(1, 32'h504, ALU, 5'd0, 5'd0, 5'd7, 1'b1);
    accept(2'b10);
    step();
    checks++; if (l_flag !== 4'b0001 || eu_pc[31:0] !== 32'h504 || eu_rd[4:0] !== 5'd7)
      begin errors++; $display("FAIL sb_compact got f=%b pc=%h rd=%d want 0001/504/7", l_flag, eu_pc[31:0], eu_rd[4:0]); end
    set_slot(0, 32'h508, ALU, 5'd7, 5'd0, 5'd8, 1'b1);
    accept(2'b01);
    checks++; if (eu_valid !== 2'b00) begin errors++; $display("FAIL sb_stall0 got %b want 00", eu_valid); end
    step();
    step();
    checks++; if (eu_valid !== 2'b00) begin errors++; $display("FAIL sb_stall2 got %b want 00", eu_valid); end
    wb_valid = 2'b11; wb_rd = {5'd7, 5'd7}; wb_data = {32'h1111_0001, 32'h2222_0000};
    step();
    wb_valid = 2'b00;
`ifdef ISSUE_WB_BYPASS_EN
    checks++; if (eu_valid !== 2'b01 || eu_rdata1[31:0] !== 32'h1111_0001)
      begin errors++; $display("FAIL sb_bypass got v=%b d1=%h want 01/11110001", eu_valid, eu_rdata1[31:0]); end
`else
    checks++; if (eu_valid !== 2'b00) begin errors++; $display("FAIL sb_wb_cycle got %b want 00", eu_valid); end
    step();
    checks++; if (eu_valid !== 2'b01 || eu_rdata1[31:0] !== 32'h107 || eu_pc[31:0] !== 32'h508)
      begin errors++; $display("FAIL sb_issue got v=%b d1=%h pc=%h want 01/107/508", eu_valid, eu_rdata1[31:0], eu_pc[31:0]); end
`endif
    step();
    wb_one(5'd8);
  endtask

  task automatic test_structural();
    eu_ready = 2'b00;
    set_slot(0, 32'h300, BRU, 5'd1, 5'd0, 5'd0, 1'b0);
    set_slot(1, 32'h304, BRU, 5'd2, 5'd0, 5'd0, 1'b0);
    accept(2'b11);
    step();
    checks++; if (l_flag !== 4'b0001 || eu_valid !== 2'b01 || eu_pc[31:0] !== 32'h300)
      begin errors++; $display("FAIL st_first got f=%b v=%b pc=%h want 0001/01/300", l_flag, eu_valid, eu_pc[31:0]); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (eu_valid !== 2'b01 || eu_pc[31:0] !== 32'h300 || eu_rdata1[31:0] !== 32'h101 || l_flag !== 4'b0000)
        begin errors++; $display("FAIL st_hold%0d got v=%b pc=%h d1=%h f=%b want 01/300/101/0000", c, eu_valid, eu_pc[31:0], eu_rdata1[31:0], l_flag); end
    end
    eu_ready = 2'b01;
    step();
    checks++; if (eu_valid !== 2'b01 || eu_pc[31:0] !== 32'h304 || eu_rdata1[31:0] !== 32'h102 || l_flag !== 4'b0001)
      begin errors++; $display("FAIL st_second got v=%b pc=%h d1=%h f=%b want 01/304/102/0001", eu_valid, eu_pc[31:0], eu_rdata1[31:0], l_flag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL st_in_ready got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_flush();
    eu_ready = 2'b11;
    set_slot(0, 32'h600, ALU, 5'd0, 5'd0, 5'd13, 1'b1);
    set_slot(1, 32'h604, LSU, 5'd0, 5'd0, 5'd0, 1'b1);
    accept(2'b11);
    step();
    step();
    eu_ready = 2'b00;
    set_slot(0, 32'h610, ALU, 5'd0, 5'd0, 5'd0, 1'b0);
    set_slot(1, 32'h614, LSU, 5'd0, 5'd0, 5'd0, 1'b0);
    accept(2'b11);
    step();
    checks++; if (eu_valid !== 2'b11) begin errors++; $display("FAIL fl_setup got %b want 11", eu_valid); end
    set_slot(0, 32'h618, ALU, 5'd0, 5'd0, 5'd0, 1'b0);
    set_slot(1, 32'h61C, ALU, 5'd0, 5'd0, 5'd0, 1'b0);
    accept(2'b11);
    step();
    checks++; if (eu_valid !== 2'b11 || in_ready !== 1'b0 || eu_pc !== {32'h614, 32'h610})
      begin errors++; $display("FAIL fl_full got v=%b rdy=%b pc=%h want 11/0/614_610", eu_valid, in_ready, eu_pc); end
    flush = 1'b1; in_valid = 2'b01;
    step();
    flush = 1'b0; in_valid = 2'b00;
    checks++; if (eu_valid !== 2'b00 || in_ready !== 1'b1 || l_flag !== 4'b0000)
      begin errors++; $display("FAIL fl_after got v=%b rdy=%b f=%b want 00/1/0000", eu_valid, in_ready, l_flag); end
    step();
    checks++; if (eu_valid !== 2'b00) begin errors++; $display("FAIL fl_empty got %b want 00", eu_valid); end
    // flush while the hold is empty and ready: the offered pair is dropped
    eu_ready = 2'b11;
    set_slot(0, 32'h6F0, ALU, 5'd0, 5'd0, 5'd0, 1'b0);
    flush = 1'b1; in_valid = 2'b01;
    step();
    flush = 1'b0; in_valid = 2'b00;
    step();
    checks++; if (eu_valid !== 2'b00 || in_ready !== 1'b1)
      begin errors++; $display("FAIL fl_no_accept got v=%b rdy=%b want 00/1", eu_valid, in_ready); end
    // x13 stays pending across the flush
    set_slot(0, 32'h620, ALU, 5'd13, 5'd0, 5'd14, 1'b1);
    accept(2'b01);
    step();
    step();
    checks++; if (eu_valid !== 2'b00) begin errors++; $display("FAIL fl_pending_kept got %b want 00", eu_valid); end
    wb_one(5'd13);
`ifdef ISSUE_WB_BYPASS_EN
`else
    step();
`endif
    checks++; if (eu_valid !== 2'b01 || eu_pc[31:0] !== 32'h620)
      begin errors++; $display("FAIL fl_release got v=%b pc=%h want 01/620", eu_valid, eu_pc[31:0]); end
    // an earlier x0 destination must not block a later rd=x0
    set_slot(0, 32'h630, ALU, 5'd0, 5'd0, 5'd0, 1'b1);
    accept(2'b01);
    step();
    checks++; if (eu_valid !== 2'b01 || eu_pc[31:0] !== 32'h630 || l_flag !== 4'b0001)
      begin errors++; $display("FAIL fl_x0_dest got v=%b pc=%h f=%b want 01/630/0001", eu_valid, eu_pc[31:0], l_flag); end
    step();
    wb_one(5'd14);
  endtask

  task automatic test_mid_reset();
    eu_ready = 2'b00;
    set_slot(0, 32'h700, ALU, 5'd0, 5'd0, 5'd15, 1'b1);
    set_slot(1, 32'h704, LSU, 5'd0, 5'd0, 5'd16, 1'b1);
    accept(2'b11);
    step();
    checks++; if (eu_valid !== 2'b11) begin errors++; $display("FAIL mr_setup got %b want 11", eu_valid); end
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    checks++; if (eu_valid !== 2'b00 || in_ready !== 1'b1 || l_flag !== 4'b0000 || eu_pc !== '0)
      begin errors++; $display("FAIL mr_state got v=%b rdy=%b f=%b pc=%h want 00/1/0000/0", eu_valid, in_ready, l_flag, eu_pc); end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_intra_raw();
    test_scoreboard();
    test_structural();
    test_flush();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
